// File: rtl/goertzel_seq_ctrl_if.sv
// rtl/goertzel_seq_ctrl_if.sv - coefficient ROM, sample, result and status signals of goertzel_seq_ctrl
// slave is the sequencer's view; master is the surrounding datapath/ROM/stream environment.
interface goertzel_seq_ctrl_if #(
   parameter int NUM_FREQS = 256,
   parameter int COEF_SIZE = 8
);
   localparam int AW = (NUM_FREQS > 1) ? $clog2(NUM_FREQS) : 1;

   logic                 cfg_start;
   logic                 coef_rd_en;
   logic [AW-1:0]        coef_rd_addr;
   logic [COEF_SIZE-1:0] coef_rd_data;
   logic [COEF_SIZE-1:0] goertzel_coefs;
   logic                 goertzel_coefs_start;
   logic                 goertzel_coefs_done;
   logic [15:0]          s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [15:0]          framed_out;
   logic                 framed_valid;
   logic [31:0]          dft_out;
   logic                 dft_valid;
   logic [31:0]          m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 frame_done;
   logic                 busy;
   logic                 err_overflow;
   logic                 err_timeout;

   modport slave (
      input  cfg_start, coef_rd_data, goertzel_coefs_done, s_data, s_valid,
             dft_out, dft_valid, m_ready,
      output coef_rd_en, coef_rd_addr, goertzel_coefs, goertzel_coefs_start, s_ready,
             framed_out, framed_valid, m_data, m_valid, frame_done, busy,
             err_overflow, err_timeout
   );

   modport master (
      output cfg_start, coef_rd_data, goertzel_coefs_done, s_data, s_valid,
             dft_out, dft_valid, m_ready,
      input  coef_rd_en, coef_rd_addr, goertzel_coefs, goertzel_coefs_start, s_ready,
             framed_out, framed_valid, m_data, m_valid, frame_done, busy,
             err_overflow, err_timeout
   );
endinterface

// File: rtl/goertzel_seq_ctrl.sv
// rtl/goertzel_seq_ctrl.sv - Goertzel coefficient loader, sample gate and DFT result buffer
// Optional WAIT_DONE watchdog enabled by defining GOERTZEL_SEQ_TIMEOUT_EN.
module goertzel_seq_ctrl #(
   parameter int NUM_FREQS = 256,
   parameter int COEF_SIZE = 8,
   parameter int FRAME_LEN = 400,
   parameter int TIMEOUT   = 1024
) (
   input logic clk,
   input logic rst_n,
   goertzel_seq_ctrl_if.slave bus
);
   localparam int AW = (NUM_FREQS > 1) ? $clog2(NUM_FREQS) : 1;
   localparam int CW = $clog2(FRAME_LEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   localparam logic [AW-1:0] LAST_ADDR   = AW'(NUM_FREQS - 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(FRAME_LEN - 1);

   logic [1:0]           state;
   logic [AW-1:0]        addr_cnt;
   logic                 issue_done;
   logic [CW-1:0]        sample_cnt;
   logic                 coefs_start_q;
   logic [COEF_SIZE-1:0] coefs_q;
   logic [15:0]          framed_q;
   logic                 framed_valid_q;
   logic                 frame_done_q;
   logic [31:0]          m_data_q;
   logic                 m_valid_q;
   logic                 err_overflow_q;
   logic                 rd_en;
   logic                 accept;
   logic                 cfg_act;
   logic                 timeout_hit;

   // cfg_start only acts where a (re)load is allowed; LOAD/WAIT_DONE ignore it
   assign cfg_act = bus.cfg_start && (state == S_IDLE || state == S_RUN);
   assign rd_en   = (state == S_LOAD) && !issue_done;
   assign accept  = (state == S_RUN) && !bus.cfg_start && bus.s_valid;

   assign bus.coef_rd_en           = rd_en;
   assign bus.coef_rd_addr         = addr_cnt;
   assign bus.goertzel_coefs       = coefs_q;
   assign bus.goertzel_coefs_start = coefs_start_q;
   assign bus.s_ready              = (state == S_RUN) && !bus.cfg_start;
   assign bus.framed_out           = framed_q;
   assign bus.framed_valid         = framed_valid_q;
   assign bus.frame_done           = frame_done_q;
   assign bus.m_data               = m_data_q;
   assign bus.m_valid              = m_valid_q;
   assign bus.busy                 = (state != S_IDLE);
   assign bus.err_overflow         = err_overflow_q;

`ifdef GOERTZEL_SEQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wd_cnt;
   logic          err_timeout_q;

   assign timeout_hit     = (state == S_WAIT) && !bus.goertzel_coefs_done &&
                            (wd_cnt == WW'(TIMEOUT - 1));
   assign bus.err_timeout = err_timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt        <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         if (state == S_WAIT && !bus.goertzel_coefs_done)
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
         if (cfg_act)
            err_timeout_q <= 1'b0;
         else if (timeout_hit)
            err_timeout_q <= 1'b1;
      end
   end
`else
   assign timeout_hit     = 1'b0;
   assign bus.err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_cnt   <= '0;
         issue_done <= 1'b0;
         sample_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_act) begin
                  state      <= S_LOAD;
                  addr_cnt   <= '0;
                  issue_done <= 1'b0;
               end
            end
            S_LOAD: begin
               if (rd_en) begin
                  if (addr_cnt == LAST_ADDR)
                     issue_done <= 1'b1;
                  else
                     addr_cnt <= addr_cnt + 1'b1;
               end else begin
                  // last strobe is on the output now; a done pulse alongside it is taken
                  state      <= bus.goertzel_coefs_done ? S_RUN : S_WAIT;
                  addr_cnt   <= '0;
                  issue_done <= 1'b0;
                  sample_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (bus.goertzel_coefs_done) begin
                  state      <= S_RUN;
                  sample_cnt <= '0;
               end else if (timeout_hit) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               if (cfg_act) begin
                  state      <= S_LOAD;
                  addr_cnt   <= '0;
                  issue_done <= 1'b0;
                  sample_cnt <= '0;
               end else if (accept) begin
                  sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coefs_start_q  <= 1'b0;
         coefs_q        <= '0;
         framed_q       <= '0;
         framed_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         coefs_start_q  <= rd_en;
         if (rd_en)
            coefs_q <= bus.coef_rd_data;
         framed_valid_q <= accept;
         frame_done_q   <= accept && (sample_cnt == LAST_SAMPLE);
         if (accept)
            framed_q <= bus.s_data;
      end
   end

   // single-entry result buffer: a new result replaces the held one only if it is leaving
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q       <= '0;
         m_valid_q      <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         if (bus.dft_valid && (!m_valid_q || bus.m_ready)) begin
            m_data_q  <= bus.dft_out;
            m_valid_q <= 1'b1;
         end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
         if (cfg_act)
            err_overflow_q <= 1'b0;
         else if (bus.dft_valid && m_valid_q && !bus.m_ready)
            err_overflow_q <= 1'b1;
      end
   end
endmodule
